// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the memory-side strobes of mem_port_arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
);
    logic                  req0, req1;
    logic                  we0, we1;
    logic                  lock0, lock1;
    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  gnt0, gnt1;
    logic                  rvalid0, rvalid1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  mem_en, mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  busy;
    logic                  owner;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_en, mem_we, mem_addr, mem_wdata,
               busy, owner
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_en, mem_we, mem_addr, mem_wdata,
               busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer for the CPU's single-port synchronous memory.
// One access at a time: IDLE -> ACCESS (-> RESP for reads) -> IDLE.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int PRIO_MODE  = 0
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t                state, state_nx;
    logic                  last_grant, last_grant_nx;
    logic                  owner_q, owner_nx;
    logic                  lock_pend, lock_pend_nx;
    logic                  lat_we, lat_we_nx;
    logic [ADDR_WIDTH-1:0] lat_addr, lat_addr_nx;
    logic [DATA_WIDTH-1:0] lat_wdata, lat_wdata_nx;
    logic                  gnt0_q, gnt0_nx, gnt1_q, gnt1_nx;
    logic                  rvalid0_q, rvalid0_nx, rvalid1_q, rvalid1_nx;
    logic                  mem_en_q, mem_en_nx, mem_we_q, mem_we_nx;
    logic                  busy_q, busy_nx;
    logic                  win;

    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        owner_nx      = owner_q;
        lock_pend_nx  = lock_pend;
        lat_we_nx     = lat_we;
        lat_addr_nx   = lat_addr;
        lat_wdata_nx  = lat_wdata;
        gnt0_nx       = 1'b0;
        gnt1_nx       = 1'b0;
        rvalid0_nx    = 1'b0;
        rvalid1_nx    = 1'b0;
        mem_en_nx     = 1'b0;
        mem_we_nx     = 1'b0;
        busy_nx       = 1'b0;

        // A pending lock only holds while its owner is still requesting.
        if (lock_pend && (owner_q ? bus.req1 : bus.req0))
            win = owner_q;
        else if (bus.req0 ^ bus.req1)
            win = bus.req1;
        else if (PRIO_MODE == 1)
            win = 1'b0;
        else
            win = ~last_grant;

        case (state)
            IDLE: begin
                lock_pend_nx = 1'b0;
                if (bus.req0 | bus.req1) begin
                    state_nx      = ACCESS;
                    last_grant_nx = win;
                    owner_nx      = win;
                    lat_we_nx     = win ? bus.we1 : bus.we0;
                    lat_addr_nx   = win ? bus.addr1 : bus.addr0;
                    lat_wdata_nx  = win ? bus.wdata1 : bus.wdata0;
                    gnt0_nx       = ~win;
                    gnt1_nx       = win;
                    mem_en_nx     = 1'b1;
                    mem_we_nx     = lat_we_nx;
                    busy_nx       = 1'b1;
                end
            end
            ACCESS: begin
                lock_pend_nx = owner_q ? bus.lock1 : bus.lock0;
                if (lat_we) begin
                    state_nx = IDLE;
                end else begin
                    state_nx   = RESP;
                    rvalid0_nx = ~owner_q;
                    rvalid1_nx = owner_q;
                    busy_nx    = 1'b1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner_q    <= 1'b0;
            lock_pend  <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            owner_q    <= owner_nx;
            lock_pend  <= lock_pend_nx;
            lat_we     <= lat_we_nx;
            lat_addr   <= lat_addr_nx;
            lat_wdata  <= lat_wdata_nx;
            gnt0_q     <= gnt0_nx;
            gnt1_q     <= gnt1_nx;
            rvalid0_q  <= rvalid0_nx;
            rvalid1_q  <= rvalid1_nx;
            mem_en_q   <= mem_en_nx;
            mem_we_q   <= mem_we_nx;
            busy_q     <= busy_nx;
        end
    end

    // Address/data registers double as the memory bus; only meaningful while mem_en.
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
    assign bus.rdata     = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: round-robin and fixed-priority instances share stimulus,
// each checked cycle by cycle against a transaction-level model plus directed scenarios.
module tb_mem_port_arbiter;
    logic clk, rst;
    logic req0, req1, we0, we1, lock0, lock1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) if_rr ();
    mem_port_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) if_fp ();

    mem_port_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .PRIO_MODE(0)) u_rr (
        .clk(clk), .rst(rst), .bus(if_rr.slave));
    mem_port_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .PRIO_MODE(1)) u_fp (
        .clk(clk), .rst(rst), .bus(if_fp.slave));

    assign if_rr.req0 = req0;   assign if_fp.req0 = req0;
    assign if_rr.req1 = req1;   assign if_fp.req1 = req1;
    assign if_rr.we0 = we0;     assign if_fp.we0 = we0;
    assign if_rr.we1 = we1;     assign if_fp.we1 = we1;
    assign if_rr.lock0 = lock0; assign if_fp.lock0 = lock0;
    assign if_rr.lock1 = lock1; assign if_fp.lock1 = lock1;
    assign if_rr.addr0 = addr0; assign if_fp.addr0 = addr0;
    assign if_rr.addr1 = addr1; assign if_fp.addr1 = addr1;
    assign if_rr.wdata0 = wdata0; assign if_fp.wdata0 = wdata0;
    assign if_rr.wdata1 = wdata1; assign if_fp.wdata1 = wdata1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories, one per instance
    logic [7:0] mem_rr [32];
    logic [7:0] mem_fp [32];
    always @(posedge clk) begin
        if (if_rr.mem_en && if_rr.mem_we) mem_rr[if_rr.mem_addr] <= if_rr.mem_wdata;
        if (if_rr.mem_en && !if_rr.mem_we) if_rr.mem_rdata <= mem_rr[if_rr.mem_addr];
        if (if_fp.mem_en && if_fp.mem_we) mem_fp[if_fp.mem_addr] <= if_fp.mem_wdata;
        if (if_fp.mem_en && !if_fp.mem_we) if_fp.mem_rdata <= mem_fp[if_fp.mem_addr];
    end
    initial begin
        for (int i = 0; i < 32; i++) begin
            mem_rr[i] <= (i == 10) ? 8'h3C : 8'(i * 7 + 3);
            mem_fp[i] <= (i == 10) ? 8'h3C : 8'(i * 7 + 3);
        end
    end

    // Reference model: index 0 = round-robin, 1 = fixed priority
    int         m_left [2];   // cycles of the current transaction still to show, 0 = idle
    bit         m_ph [2];     // 0 = access cycle, 1 = response cycle
    bit         m_own [2], m_we [2], m_last [2], m_lockp [2];
    logic [4:0] m_addr [2];
    logic [7:0] m_wdata [2];
    logic [7:0] ref_mem [2][32];
    int         gq0[$], gq1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; m_ph[k] = 0; m_own[k] = 0; m_we[k] = 0;
            m_last[k] = 1; m_lockp[k] = 0; m_addr[k] = '0; m_wdata[k] = '0;
        end
    endtask

    task automatic model_step();
        logic [1:0] r;
        int w;
        r = {req1, req0};
        for (int k = 0; k < 2; k++) begin
            if (m_left[k] == 0) begin
                if (r != 2'b00) begin
                    if (m_lockp[k] && r[m_own[k]]) w = int'(m_own[k]);
                    else if (r == 2'b01) w = 0;
                    else if (r == 2'b10) w = 1;
                    else if (k == 1) w = 0;
                    else w = m_last[k] ? 0 : 1;
                    m_own[k]   = (w == 1);
                    m_last[k]  = (w == 1);
                    m_we[k]    = (w == 1) ? we1 : we0;
                    m_addr[k]  = (w == 1) ? addr1 : addr0;
                    m_wdata[k] = (w == 1) ? wdata1 : wdata0;
                    m_left[k]  = m_we[k] ? 1 : 2;
                    m_ph[k]    = 0;
                end
                m_lockp[k] = 0;
            end else begin
                if (!m_ph[k]) begin
                    m_lockp[k] = m_own[k] ? lock1 : lock0;
                    if (m_we[k]) ref_mem[k][m_addr[k]] = m_wdata[k];
                end
                m_left[k] = m_left[k] - 1;
                m_ph[k]   = 1;
            end
        end
    endtask

    // {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy, owner}
    function automatic logic [7:0] exp_ctl(input int k);
        bit acc, rsp;
        acc = (m_left[k] > 0) && !m_ph[k];
        rsp = (m_left[k] > 0) && m_ph[k];
        return {acc && !m_own[k], acc && m_own[k], rsp && !m_own[k], rsp && m_own[k],
                acc, acc && m_we[k], m_left[k] > 0, m_own[k]};
    endfunction

    function automatic logic [7:0] obs_ctl(input int k);
        if (k == 0)
            return {if_rr.gnt0, if_rr.gnt1, if_rr.rvalid0, if_rr.rvalid1,
                    if_rr.mem_en, if_rr.mem_we, if_rr.busy, if_rr.owner};
        return {if_fp.gnt0, if_fp.gnt1, if_fp.rvalid0, if_fp.rvalid1,
                if_fp.mem_en, if_fp.mem_we, if_fp.busy, if_fp.owner};
    endfunction

    // {mem_addr, mem_wdata, rdata}
    function automatic logic [20:0] obs_bus(input int k);
        if (k == 0) return {if_rr.mem_addr, if_rr.mem_wdata, if_rr.rdata};
        return {if_fp.mem_addr, if_fp.mem_wdata, if_fp.rdata};
    endfunction

    task automatic check_both();
        logic [20:0] b;
        for (int k = 0; k < 2; k++) begin
            b = obs_bus(k);
            chk($sformatf("ctl%0d", k), 32'(obs_ctl(k)), 32'(exp_ctl(k)));
            if (m_left[k] > 0 && !m_ph[k]) begin
                chk($sformatf("addr%0d", k), 32'(b[20:16]), 32'(m_addr[k]));
                if (m_we[k]) chk($sformatf("wdata%0d", k), 32'(b[15:8]), 32'(m_wdata[k]));
            end
            if (m_left[k] > 0 && m_ph[k])
                chk($sformatf("rdata%0d", k), 32'(b[7:0]), 32'(ref_mem[k][m_addr[k]]));
        end
    endtask

    task automatic cyc();
        logic [7:0] c;
        @(posedge clk);
        #1;
        if (rst) model_reset(); else model_step();
        check_both();
        c = obs_ctl(0);
        if (c[7]) gq0.push_back(0);
        if (c[6]) gq0.push_back(1);
        c = obs_ctl(1);
        if (c[7]) gq1.push_back(0);
        if (c[6]) gq1.push_back(1);
    endtask

    task automatic drain(input int n);
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic chk_bit(input string tag, input int bitpos, input logic v);
        logic [7:0] c;
        for (int k = 0; k < 2; k++) begin
            c = obs_ctl(k);
            chk($sformatf("%s_%0d", tag, k), 32'(c[bitpos]), 32'(v));
        end
    endtask

    task automatic chk_order(input string tag, input int q[$], input int e[4], input int n);
        chk({tag, "_n"}, 32'(q.size()), 32'(n));
        for (int i = 0; i < n; i++)
            if (i < q.size()) chk($sformatf("%s_%0d", tag, i), 32'(q[i]), 32'(e[i]));
    endtask

    initial begin
        int e_rr[4], e_fp[4], e_lk[4];
        logic [20:0] b;
        rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++) ref_mem[k][i] = (i == 10) ? 8'h3C : 8'(i * 7 + 3);
        model_reset();

        // reset state
        cyc(); cyc();
        for (int k = 0; k < 2; k++) begin
            b = obs_bus(k);
            chk($sformatf("rst_ctl%0d", k), 32'(obs_ctl(k)), 32'd0);
            chk($sformatf("rst_addr%0d", k), 32'(b[20:16]), 32'd0);
        end
        rst = 0;

        // 1: single read of 0x0A
        req0 = 1; we0 = 0; addr0 = 5'h0A;
        cyc();
        chk_bit("t1_gnt0", 7, 1'b1);
        chk_bit("t1_en", 3, 1'b1);
        b = obs_bus(0);
        chk("t1_addr", 32'(b[20:16]), 32'h0A);
        req0 = 0;
        cyc();
        chk_bit("t1_rvalid0", 5, 1'b1);
        b = obs_bus(0);
        chk("t1_rdata", 32'(b[7:0]), 32'h3C);
        cyc();
        chk_bit("t1_busy", 1, 1'b0);

        // 2: port1 write 0x1F then read back
        req1 = 1; we1 = 1; addr1 = 5'h1F; wdata1 = 8'hA5;
        cyc();
        chk_bit("t2_we_acc", 2, 1'b1);
        chk_bit("t2_gnt1w", 6, 1'b1);
        we1 = 0;
        cyc();
        chk_bit("t2_we_idle", 2, 1'b0);
        cyc();
        chk_bit("t2_we_rd", 2, 1'b0);
        chk_bit("t2_gnt1r", 6, 1'b1);
        req1 = 0;
        cyc();
        chk_bit("t2_rvalid1", 4, 1'b1);
        b = obs_bus(0);
        chk("t2_rdata", 32'(b[7:0]), 32'hA5);
        drain(1);

        // 3: continuous contention
        gq0.delete(); gq1.delete();
        req0 = 1; req1 = 1; we0 = 0; we1 = 0;
        for (int i = 0; i < 12; i++) cyc();
        req0 = 0; req1 = 0;
        e_rr = '{0, 1, 0, 1};
        e_fp = '{0, 0, 0, 0};
        chk_order("t3_rr", gq0, e_rr, 4);
        chk_order("t3_fp", gq1, e_fp, 4);
        drain(2);

        // 4: locked port1 reads while port0 waits
        gq0.delete(); gq1.delete();
        req1 = 1; lock1 = 1; we1 = 0; addr1 = 5'h03;
        cyc();
        req0 = 1; we0 = 0; addr0 = 5'h04;
        for (int i = 0; i < 6; i++) cyc();
        req1 = 0; lock1 = 0;
        for (int i = 0; i < 3; i++) cyc();
        req0 = 0;
        drain(3);
        e_lk = '{1, 1, 1, 0};
        chk_order("t4_rr", gq0, e_lk, 4);
        chk_order("t4_fp", gq1, e_lk, 4);

        // 5: reset during RESP of a port0 read
        req0 = 1; we0 = 0; addr0 = 5'h0A;
        cyc();
        req0 = 0;
        cyc();
        rst = 1;
        #1;
        model_reset();
        chk_bit("t5_rvalid0", 5, 1'b0);
        chk_bit("t5_busy", 1, 1'b0);
        chk_bit("t5_en", 3, 1'b0);
        check_both();
        cyc();
        rst = 0;
        req0 = 1; req1 = 1;
        cyc();
        chk_bit("t5_tie_gnt0", 7, 1'b1);
        drain(3);

        // 6: req0 drops and addr0 moves during ACCESS
        req0 = 1; we0 = 0; addr0 = 5'h0A;
        cyc();
        b = obs_bus(0);
        chk("t6_addr", 32'(b[20:16]), 32'h0A);
        req0 = 0; addr0 = 5'h03;
        cyc();
        chk_bit("t6_rvalid0", 5, 1'b1);
        b = obs_bus(0);
        chk("t6_rdata", 32'(b[7:0]), 32'h3C);
        cyc();
        chk_bit("t6_rvalid0_once", 5, 1'b0);
        drain(1);

        // Randomized traffic, including occasional async resets
        for (int n = 0; n < 3000; n++) begin
            req0   = ($urandom_range(0, 2) != 0);
            req1   = ($urandom_range(0, 2) != 0);
            we0    = $urandom_range(0, 1) == 1;
            we1    = $urandom_range(0, 1) == 1;
            lock0  = ($urandom_range(0, 3) == 0);
            lock1  = ($urandom_range(0, 3) == 0);
            addr0  = 5'($urandom);
            addr1  = 5'($urandom);
            wdata0 = 8'($urandom);
            wdata1 = 8'($urandom);
            if ($urandom_range(0, 249) == 0) begin
                rst = 1;
                #1;
                model_reset();
                check_both();
                cyc();
                rst = 0;
            end
            cyc();
        end
        drain(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
